inst_fetch_queue: RTL
=====================

# inst_fetch_queue

Parametrised instruction fetch unit with a decoupling queue between instruction memory and the decoder. It owns the PC, issues one outstanding fetch at a time, and buffers up to `QUEUE_DEPTH` fetched (pc, inst) pairs. It applies redirects from the ROB (mispredict/clear) and the decoder (direct jump), discarding stale in-flight responses. It sits between the memory controller's instruction port and the decoder.

## Interface
- `XLEN`, 32, PC and instruction width.
- `QUEUE_DEPTH`, 4, entries in the fetch queue; power of two, ≥2.
- `RESET_PC`, 32'h0, PC value after reset.
- `clk_in`  in  1  system clock; all state updates on the rising edge.
- `rst_in`  in  1  reset, asynchronous, active-high.
- `rdy_in`  in  1  global ready; when low, all state is frozen and `_mem_req` is forced to 0.
- `_clear`  in  1  ROB flush; must be accompanied by `_br_rob`.
- `_br_rob`  in  1  ROB redirect valid.
- `_rob_new_pc`  in  XLEN  ROB redirect target.
- `_br_dc`  in  1  decoder redirect valid.
- `_dc_new_pc`  in  XLEN  decoder redirect target.
- `_mem_req`  out  1  one-cycle fetch request pulse.
- `_mem_pc`  out  XLEN  fetch address, valid with `_mem_req`.
- `_inst_in`  in  XLEN  fetched instruction.
- `_inst_ready_in`  in  1  one-cycle response strobe for the outstanding request.
- `_stall`  in  1  decoder cannot accept this cycle.
- `_inst_ready_out`  out  1  head entry valid for the decoder.
- `_pc`  out  XLEN  PC of the head entry.
- `_inst_out`  out  XLEN  instruction of the head entry.

## Operation
- State: `fetch_pc`, a ring buffer (head, tail, count), `outstanding`, and `drop`.
- Redirect (`redir`) = `_br_rob | _clear | _br_dc`. Target priority: ROB target over decoder target. When `_clear` is high, `_rob_new_pc` is used.
- On `redir`:
  - `fetch_pc` ← target.
  - Queue is emptied (count=0, head=tail).
  - If a request is outstanding and its response does not arrive this cycle, `drop` ← 1.
  - No request is issued this cycle.
- Issue a request when all of the following hold: `rdy_in`, `!redir`, `!outstanding`, and `count < QUEUE_DEPTH`.
  - On issue, `_mem_req`=1, `_mem_pc`=`fetch_pc`.
  - `fetch_pc` ← `fetch_pc`+4, modulo 2^XLEN.
  - `outstanding` ← 1.
- On a response (`_inst_ready_in`, sampled only when `rdy_in`=1):
  - `outstanding` ← 0.
  - If `drop`=1 or `redir`=1, the response is discarded and `drop` ← 0.
  - Otherwise (pc of the request, `_inst_in`) is pushed at the tail.
- Response with no outstanding request: ignored (protocol error; flagged by an assertion).
- Output: `_inst_ready_out` = `count>0 & !redir`. Head fields are driven combinationally from the buffer.
- Pop when `_inst_ready_out & !_stall & rdy_in`.
- Push and pop in the same cycle: count is unchanged, and a full queue still accepts the response.
- The request pc is held in a register alongside `outstanding`, so the response carries its own pc.

## Timing
- Reset values: `fetch_pc`=`RESET_PC`, count=0, head=tail=0, `outstanding`=0, `drop`=0, `_mem_req`=0, `_inst_ready_out`=0, `_pc`/`_inst_out`=0 while empty.
- Reset asserted mid-operation clears everything immediately. A response arriving in the first cycle after reset is ignored.
- Latency:
  - The first request issues in the first `rdy_in` cycle after reset release.
  - A response at cycle t is visible at `_inst_ready_out` in cycle t+1.
- After a redirect at cycle t:
  - With no outstanding request, the request to the target issues at t+1.
  - With an outstanding request, it issues the cycle after the stale response is dropped.
- `rdy_in`=0: no register changes, `_mem_req`=0, and outputs hold their values.

## Structure
- Shared package: `XLEN` default, instruction-length constant 4, `RESET_PC` default.
- Sub-module `fetch_ring_buffer`:
  - Parameters: width 2·XLEN, `QUEUE_DEPTH`.
  - Ports: push, pop, flush, full, empty, head data.
  - Pointers are log2(`QUEUE_DEPTH`) bits and wrap naturally; count is log2(`QUEUE_DEPTH`)+1 bits.

## Test plan
- Reset with `RESET_PC`=0, memory latency 3, `_stall`=0 → requests at pc 0,4,8…; decoder sees (0,I0),(4,I1) in order, with one request in flight at a time.
- `_stall`=1 held with `QUEUE_DEPTH`=4 → after 4 responses `_mem_req` stays 0. Release `_stall` for one cycle → one pop, one new request at pc 16.
- `_br_dc` with target 0x100 while a request to 0x8 is in flight → the 0x8 response is dropped, and the next request and output are at 0x100.
- `_br_rob`(0x200) and `_br_dc`(0x100) in the same cycle → fetch resumes at 0x200 and the queue is empty in the next cycle.
- Redirect in the same cycle as the response → the response is discarded, `drop` stays 0, and the request to the target issues next cycle.
- `rdy_in`=0 for 5 cycles mid-stream → no state change, and output ordering resumes unchanged.

Source files
------------

// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants for the instruction fetch unit and its decoupling queue.
package inst_fetch_queue_pkg;

  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam int unsigned INST_LEN         = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;

endpackage

// File: rtl/fetch_ring_buffer.sv
// Power-of-two ring buffer holding fetched (pc, inst) pairs; head is read combinationally.
module fetch_ring_buffer #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [Width-1:0] head_data
);

  localparam int unsigned   PtrW    = $clog2(Depth);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [PtrW:0]   CntOne  = (PtrW+1)'(1);
  localparam logic [PtrW:0]   CntFull = (PtrW+1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [PtrW:0]    count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PtrOne;
      if (pop)  head_d = head_q + PtrOne;
      if (push && !pop)      count_d = count_q + CntOne;
      else if (pop && !push) count_d = count_q - CntOne;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk_in) begin
    if (push && !flush) mem_q[tail_q] <= push_data;
  end

  assign full      = (count_q == CntFull);
  assign empty     = (count_q == '0);
  assign head_data = empty ? '0 : mem_q[head_q];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch unit: owns the PC, keeps one fetch in flight and buffers responses
// for the decoder, discarding responses made stale by ROB or decoder redirects.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned     XLEN        = XLEN_DEFAULT,
  parameter int unsigned     QUEUE_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  input  logic            _clear,
  input  logic            _br_rob,
  input  logic [XLEN-1:0] _rob_new_pc,
  input  logic            _br_dc,
  input  logic [XLEN-1:0] _dc_new_pc,
  output logic            _mem_req,
  output logic [XLEN-1:0] _mem_pc,
  input  logic [XLEN-1:0] _inst_in,
  input  logic            _inst_ready_in,
  input  logic            _stall,
  output logic            _inst_ready_out,
  output logic [XLEN-1:0] _pc,
  output logic [XLEN-1:0] _inst_out
);

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   req_pc_q, req_pc_d;
  logic              outstanding_q, outstanding_d;
  logic              drop_q, drop_d;

  logic              redir, issue, resp, push, pop, full, empty;
  logic [XLEN-1:0]   target;
  logic [2*XLEN-1:0] head_data;

  assign redir  = _br_rob | _clear | _br_dc;
  assign target = (_br_rob | _clear) ? _rob_new_pc : _dc_new_pc;
  assign issue  = rdy_in & !rst_in & !redir & !outstanding_q & !full;
  // Strobes without a request in flight are protocol errors and are ignored.
  assign resp   = rdy_in & _inst_ready_in & outstanding_q;
  assign push   = resp & !drop_q & !redir;
  assign pop    = _inst_ready_out & !_stall & rdy_in;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    if (rdy_in) begin
      if (redir) begin
        fetch_pc_d = target;
      end else if (issue) begin
        fetch_pc_d = fetch_pc_q + XLEN'(INST_LEN);
        req_pc_d   = fetch_pc_q;
      end
      if (issue) begin
        outstanding_d = 1'b1;
      end else if (resp) begin
        outstanding_d = 1'b0;
      end
      if (resp) begin
        drop_d = 1'b0;
      end else if (redir && outstanding_q) begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      fetch_pc_q    <= RESET_PC;
      req_pc_q      <= '0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  fetch_ring_buffer #(
    .Width (2 * XLEN),
    .Depth (QUEUE_DEPTH)
  ) u_ring (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (push),
    .push_data ({req_pc_q, _inst_in}),
    .pop       (pop),
    .flush     (rdy_in & redir),
    .full      (full),
    .empty     (empty),
    .head_data (head_data)
  );

  assign _mem_req        = issue;
  assign _mem_pc         = fetch_pc_q;
  assign _inst_ready_out = !empty & !redir;
  assign _pc             = head_data[2*XLEN-1:XLEN];
  assign _inst_out       = head_data[XLEN-1:0];

  no_orphan_response : assert property (
    @(posedge clk_in) disable iff (rst_in) (rdy_in && _inst_ready_in) |-> outstanding_q
  );

endmodule
